// File: rtl/fft_spectrum_pingpong_ctrl.sv
// Ping-pong bank controller for the FFT magnitude RAM: the writer fills one bank while the
// last complete frame stays readable in the other and is streamed out over valid/ready.
module fft_spectrum_pingpong_ctrl #(
    parameter  int NPOINT = 1024,
    parameter  int MAG_W  = 16,
    parameter  int CNT_W  = 16,
    localparam int HALF   = NPOINT / 2,
    localparam int AW     = $clog2(HALF)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             wr_we_in,
    input  logic [AW-1:0]    wr_addr_in,
    input  logic [MAG_W-1:0] wr_din_in,
    output logic             ram_we,
    output logic [AW:0]      ram_waddr,
    output logic [MAG_W-1:0] ram_wdata,
    output logic [AW:0]      ram_raddr,
    input  logic [MAG_W-1:0] ram_rdata,
    input  logic             rd_start,
    output logic [MAG_W-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic             out_tlast,
    output logic             frame_ready,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_wr_bank;
    logic             r_frame_ready;
    logic [AW-1:0]    r_rd_idx;
    logic [AW:0]      r_raddr;
    logic [MAG_W-1:0] r_tdata;
    logic             r_tvalid;
    logic             r_tlast;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_frame_done;
    logic             w_accept;
    logic             w_swap;
    logic             w_drop;
    logic             w_busy;
    logic             w_capture;
    logic             w_handshake;
    logic             w_advance;
    logic             w_last_bin;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign ram_we    = wr_we_in;
    assign ram_wdata = wr_din_in;
    assign ram_waddr = {r_wr_bank, wr_addr_in};

    assign w_frame_done = wr_we_in && (wr_addr_in == AW'(HALF - 1));
    assign w_accept     = rd_start && r_frame_ready && (r_state == S_IDLE);
    // A bank swap is only safe while no stream is reading the other bank.
    assign w_swap       = w_frame_done && (r_state == S_IDLE) && !w_accept;
    assign w_drop       = w_frame_done && !w_swap;
    assign w_last_bin   = (r_rd_idx == AW'(HALF - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_HOLD;
            S_HOLD:  if (out_tready) w_state_nxt = r_tlast ? S_IDLE : S_ISSUE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != S_IDLE);
        w_capture   = (r_state == S_WAIT);
        w_handshake = (r_state == S_HOLD) && out_tready;
        w_advance   = w_handshake && !r_tlast;
    end

    // Read address is set up one state ahead so it is stable throughout ISSUE.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rd_idx <= '0;
            r_raddr  <= '0;
        end else if (w_accept) begin
            r_rd_idx <= '0;
            r_raddr  <= {~r_wr_bank, {AW{1'b0}}};
        end else if (w_advance) begin
            r_rd_idx <= r_rd_idx + AW'(1);
            r_raddr  <= {~r_wr_bank, r_rd_idx + AW'(1)};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_capture) begin
            r_tdata  <= ram_rdata;
            r_tvalid <= 1'b1;
            r_tlast  <= w_last_bin;
        end else if (w_handshake) begin
            r_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_bank     <= 1'b0;
            r_frame_ready <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_swap) begin
                r_wr_bank     <= ~r_wr_bank;
                r_frame_ready <= 1'b1;
            end else if (w_accept) begin
                r_frame_ready <= 1'b0;
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign ram_raddr   = r_raddr;
    assign out_tdata   = r_tdata;
    assign out_tvalid  = r_tvalid;
    assign out_tlast   = r_tlast;
    assign frame_ready = r_frame_ready;
    assign busy        = w_busy;
    assign drop_cnt    = r_drop_cnt;

endmodule
